// File: rtl/neuron_event_rx_if.sv
// Byte-stream handshake carrying framed event bytes into the neuron event receiver.
interface neuron_event_rx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/neuron_event_rx.sv
// Input-side event decoder: 2-entry byte FIFO, config/event decode, synapse weight
// table and optional auto-tick generator driving registered per-event strobes.
module neuron_event_rx #(
  parameter logic [1:0] RESET_WEIGHT      = 2'd0,
  parameter logic [7:0] RESET_TICK_PERIOD = 8'd0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  neuron_event_rx_if.slave         bus,
  input  logic                     i_core_busy,
  output logic                     o_active_event,
  output logic                     o_is_tick,
  output logic [1:0]               o_w_eff,
  output logic                     o_stream_act,
  output logic                     o_learn_en,
  output logic                     o_rx_err
);

  localparam logic [0:0] ST_IDLE        = 1'b0;
  localparam logic [0:0] ST_WAIT_PERIOD = 1'b1;

  localparam logic [2:0] TYPE_SYN      = 3'd0;
  localparam logic [2:0] TYPE_TICK     = 3'd1;
  localparam logic [2:0] TYPE_CFG_W    = 3'd2;
  localparam logic [2:0] TYPE_CFG_CTRL = 3'd3;
  localparam logic [2:0] TYPE_CFG_TICK = 3'd4;

  logic [7:0] r_mem [0:1];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic [0:0] r_state;
  logic [1:0] r_weight [0:3];
  logic [7:0] r_period;
  logic [7:0] r_cnt;
  logic       r_tick_pend;
  logic       r_learn_en;
  logic       r_stream_act;
  logic       r_rx_err;
  logic       r_active;
  logic       r_is_tick;
  logic [1:0] r_w_eff;

  logic       w_full;
  logic       w_push;
  logic       w_head_vld;
  logic [7:0] w_head;
  logic       w_tick_issue;
  logic       w_wrap;
  logic       w_pop;
  logic       w_evt;
  logic       w_evt_is_tick;
  logic [1:0] w_evt_w;
  logic       w_cfg_w;
  logic       w_cfg_ctrl;
  logic       w_cfg_tick;
  logic       w_period_wr;
  logic       w_err;

  assign w_full       = (r_count == 2'd2);
  assign bus.in_ready = ~w_full;
  assign w_push       = bus.in_valid & ~w_full;
  assign w_head_vld   = (r_count != 2'd0);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_tick_issue = r_tick_pend & ~i_core_busy;
  assign w_wrap       = (r_period != 8'd0) && (r_cnt == (r_period - 8'd1));

  // Head decode: decide whether the head pops and what side effect it has.
  always_comb begin
    w_pop         = 1'b0;
    w_evt         = 1'b0;
    w_evt_is_tick = 1'b0;
    w_evt_w       = 2'd0;
    w_cfg_w       = 1'b0;
    w_cfg_ctrl    = 1'b0;
    w_cfg_tick    = 1'b0;
    w_period_wr   = 1'b0;
    w_err         = 1'b0;
    if (!w_head_vld) begin
      w_pop = 1'b0;
    end else if (r_state == ST_WAIT_PERIOD) begin
      // Operand byte is taken raw, even when bit7 is clear.
      w_pop       = 1'b1;
      w_period_wr = 1'b1;
    end else if (!w_head[7]) begin
      w_pop = 1'b1;
    end else begin
      case (w_head[6:4])
        TYPE_SYN: begin
          if (!i_core_busy && !w_tick_issue) begin
            w_pop   = 1'b1;
            w_evt   = 1'b1;
            w_evt_w = r_weight[w_head[1:0]];
          end else begin
            w_pop = 1'b0;
          end
        end
        TYPE_TICK: begin
          if (!i_core_busy && !w_tick_issue) begin
            w_pop         = 1'b1;
            w_evt         = 1'b1;
            w_evt_is_tick = 1'b1;
          end else begin
            w_pop = 1'b0;
          end
        end
        TYPE_CFG_W: begin
          w_pop   = 1'b1;
          w_cfg_w = 1'b1;
        end
        TYPE_CFG_CTRL: begin
          w_pop      = 1'b1;
          w_cfg_ctrl = 1'b1;
        end
        TYPE_CFG_TICK: begin
          w_pop      = 1'b1;
          w_cfg_tick = 1'b1;
        end
        default: begin
          w_pop = 1'b1;
          w_err = 1'b1;
        end
      endcase
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= 8'd0;
      r_mem[1] <= 8'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.in_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Decoder FSM: tracks whether the next popped byte is an auto-tick period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:        r_state <= w_cfg_tick ? ST_WAIT_PERIOD : ST_IDLE;
        ST_WAIT_PERIOD: r_state <= w_period_wr ? ST_IDLE : ST_WAIT_PERIOD;
        default:        r_state <= ST_IDLE;
      endcase
    end
  end

  // Weight table, control bits and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_weight[i] <= RESET_WEIGHT;
      end
      r_learn_en   <= 1'b0;
      r_stream_act <= 1'b0;
      r_rx_err     <= 1'b0;
    end else begin
      if (w_cfg_w) begin
        r_weight[w_head[3:2]] <= w_head[1:0];
      end
      if (w_cfg_ctrl) begin
        r_learn_en   <= w_head[0];
        r_stream_act <= w_head[1];
      end
      if (w_err) begin
        r_rx_err <= 1'b1;
      end
    end
  end

  // Auto-tick counter; a period write restarts it from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= RESET_TICK_PERIOD;
      r_cnt    <= 8'd0;
    end else if (w_period_wr) begin
      r_period <= w_head;
      r_cnt    <= 8'd0;
    end else if (r_period == 8'd0) begin
      r_cnt <= 8'd0;
    end else if (w_wrap) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Single pending tick; wraps while pending coalesce into it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_pend <= 1'b0;
    end else if (w_period_wr && (w_head == 8'd0)) begin
      r_tick_pend <= 1'b0;
    end else if (w_period_wr) begin
      r_tick_pend <= r_tick_pend & ~w_tick_issue;
    end else if (w_wrap) begin
      r_tick_pend <= 1'b1;
    end else if (w_tick_issue) begin
      r_tick_pend <= 1'b0;
    end else begin
      r_tick_pend <= r_tick_pend;
    end
  end

  // Registered event strobe; auto-tick wins over a FIFO event head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_is_tick <= 1'b0;
      r_w_eff   <= 2'd0;
    end else if (w_tick_issue) begin
      r_active  <= 1'b1;
      r_is_tick <= 1'b1;
      r_w_eff   <= 2'd0;
    end else if (w_evt) begin
      r_active  <= 1'b1;
      r_is_tick <= w_evt_is_tick;
      r_w_eff   <= w_evt_w;
    end else begin
      r_active  <= 1'b0;
      r_is_tick <= 1'b0;
      r_w_eff   <= 2'd0;
    end
  end

  assign o_active_event = r_active;
  assign o_is_tick      = r_is_tick;
  assign o_w_eff        = r_w_eff;
  assign o_stream_act   = r_stream_act;
  assign o_learn_en     = r_learn_en;
  assign o_rx_err       = r_rx_err;

endmodule

// File: doc/neuron_event_rx.md
# neuron_event_rx

Input-side event decoder for the neuron core. It accepts framed event bytes from the pin-level input interface, buffers them in a 2-entry FIFO, and decodes them into the per-event strobes the neuron mode blocks consume: `active_event`, `is_tick` and `w_eff`, plus the `stream_act` and `learn_en` controls. It owns the synapse weight table, the control bits and an optional auto-tick generator. It sits between the top-level input pins and the neuron mode blocks, whose output emitter it mirrors.

## Interface

**Parameters**
- `RESET_WEIGHT`, default 2'd0: reset value of every synapse weight entry.
- `RESET_TICK_PERIOD`, default 8'd0: reset auto-tick period; 0 means auto-tick is disabled.

**Ports**
- `clk`: input, 1 bit. Single clock for the block.
- `rst_n`: input, 1 bit. Reset, asynchronous and active-low.
- `in_data`: input, 8 bits. Event byte.
- `in_valid`: input, 1 bit. `in_data` is offered.
- `in_ready`: output, 1 bit. Byte is accepted this cycle when both `in_valid` and `in_ready` are high.
- `core_busy`: input, 1 bit. Neuron cannot take an event this cycle (for example, while learning).
- `active_event`: output, 1 bit. Registered one-cycle event strobe.
- `is_tick`: output, 1 bit. Qualifies `active_event` as a tick.
- `w_eff`: output, 2 bits. Weight for a synapse event. Zero on ticks.
- `stream_act`: output, 1 bit. Control register bit.
- `learn_en`: output, 1 bit. Control register bit.
- `rx_err`: output, 1 bit. Sticky flag for unknown event type.

## Operation

**Byte format (non-operand bytes):** `{valid, type[2:0], payload[3:0]}`. Bytes with bit7 = 0 are NOPs: they are popped and produce no effect.

**Types:**
- 0 `SYN`: payload[1:0] is the synapse index. Emits an event with `w_eff = weight[idx]` and `is_tick = 0`. payload[3:2] is ignored.
- 1 `TICK`: emits an event with `is_tick = 1` and `w_eff = 0`.
- 2 `CFG_W`: sets `weight[payload[3:2]] <= payload[1:0]`. No event.
- 3 `CFG_CTRL`: sets `learn_en <= payload[0]` and `stream_act <= payload[1]`. No event.
- 4 `CFG_TICK`: header byte. The next accepted byte is taken raw as the 8-bit auto-tick period, including values with bit7 = 0.
- 5 to 7: dropped, and `rx_err` is set to 1.

**FIFO:**
- 2 entries; `in_ready = !full`.
- No bypass path: a push into a full FIFO cannot occur.
- Push and pop in the same cycle are allowed when the FIFO is not full.

**Head processing (one head byte per cycle):**
- Config bytes, NOPs and error bytes pop regardless of `core_busy`.
- `SYN` and `TICK` pop only when `core_busy = 0` and no auto-tick is being issued that cycle. Otherwise the head is held.
- The FIFO preserves order, so a `SYN` following a `CFG_W` uses the new weight.

**Decoder FSM:**
- States are `IDLE` and `WAIT_PERIOD`.
- `IDLE` moves to `WAIT_PERIOD` when a `CFG_TICK` header pops.
- `WAIT_PERIOD` moves to `IDLE` when the next byte pops. That byte is written to `period`, and the tick counter is cleared to 0.

**Auto-tick:**
- When `period = P != 0`, an 8-bit counter runs 0 to P-1 and wraps.
- At `cnt == P-1`, `tick_pend` is set to 1.
- `tick_pend` holds a single pending tick: further wraps while it is pending are coalesced, with no error.
- A pending tick issues when `core_busy = 0`, taking priority over a FIFO `SYN`/`TICK` head, and then clears.
- Writing P = 0 stops the counter and clears both `cnt` and `tick_pend`.

**Outputs:**
- `active_event`, `is_tick` and `w_eff` are registered together.
- `w_eff` and `is_tick` are 0 whenever `active_event = 0`.

## Timing

**Reset values:**
- `active_event`, `is_tick`, `w_eff`, `rx_err` = 0.
- `stream_act`, `learn_en` = 0.
- Weights = `RESET_WEIGHT`; `period` = `RESET_TICK_PERIOD`; `cnt` = 0; `tick_pend` = 0.
- FIFO empty, so `in_ready` = 1; FSM in `IDLE`.

**Latency and throughput:**
- A byte accepted at edge N is at the head during cycle N+1.
- An event byte at the head in an eligible cycle asserts `active_event` for exactly cycle N+2.
- A config byte accepted at edge N updates its register at edge N+2, visible in cycle N+2.
- Sustained throughput is one byte per cycle with `core_busy = 0`.

**Boundary conditions:**
- `core_busy` held high: an event head stalls. Up to 2 bytes are buffered, then `in_ready` drops. `active_event` stays 0.
- Auto-tick with P = 1: `tick_pend` is set every cycle and coalesces, giving one tick per non-busy cycle. FIFO events are then starved by design.
- Asserting `rst_n` low mid-sequence (for example in `WAIT_PERIOD`) immediately restores all reset values. A partially received `CFG_TICK` is discarded.

## Test plan

1. **Reset and SYN event.** After reset, send `CFG_W` 0xA7 (idx 1, weight 3), then `SYN` 0x81. Expect `active_event = 1`, `is_tick = 0`, `w_eff = 3` for one cycle, 2 cycles after the `SYN` is accepted.
2. **Backpressure.** Hold `core_busy = 1` and push `TICK` 0x90 three times. Expect `in_ready` to fall after 2 accepts. Release `core_busy`: expect `active_event` with `is_tick = 1` on 3 consecutive cycles.
3. **Auto-tick period.** Send 0xC0 then 0x05. Expect a tick every 5 cycles. Then send 0xC0 then 0x00: expect no further ticks.
4. **Auto-tick priority.** With P = 5 running, keep a `SYN` pending at the head in the tick cycle. Expect the tick first and the `SYN` event on the next cycle.
5. **Control and NOP bytes.** Send `CFG_CTRL` 0xB3: expect `learn_en = 1` and `stream_act = 1`. Send NOP 0x7F: expect no effect.
6. **Error flag.** Send type-6 byte 0xE2: expect `rx_err = 1`, sticky across subsequent valid traffic, and no event. Then pulse `rst_n` low in `WAIT_PERIOD`: expect `rx_err = 0` and the FSM in `IDLE`.
